// File: rtl/sc_dec_pkg.sv
// Shared types and sizing helpers for the SC-decoder schedule logic.
package sc_dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

    // Width of a stage index for a code of length 2^n_bits.
    function automatic int stage_width(input int n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

    function automatic int batch_width(input int n_bits, input int num_pe);
        int w;
        w = n_bits - 1 - $clog2(num_pe);
        return (w > 1) ? w : 1;
    endfunction

    // Cycles needed to compute stage s with num_pe processing elements.
    function automatic int batches(input int s, input int num_pe);
        return ((1 << s) > num_pe) ? ((1 << s) / num_pe) : 1;
    endfunction

endpackage

// File: rtl/tz_encoder.sv
// Trailing-zero count of an n-bit value; an all-zero input maps to n-1.
module tz_encoder
    import sc_dec_pkg::*;
#(
    parameter int n = 3
) (
    input  logic [n-1:0]                value,
    output logic [stage_width(n)-1:0]   tz
);

    localparam int SW = stage_width(n);

    // NOTE: tz gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        tz = SW'(n - 1);
        for (int i = n - 1; i >= 0; i--) begin
            if (value[i]) tz = SW'(i);
        end
    end

endmodule

// File: rtl/sc_schedule_generator.sv
// SC-decoding traversal schedule: walks bit/stage/batch steps for one codeword per start.
module sc_schedule_generator
    import sc_dec_pkg::*;
#(
    parameter int n = 3,
    parameter int p = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           hold,
    output logic                           sched_valid,
    output logic [n-1:0]                   bit_index,
    output logic [stage_width(n)-1:0]      stage_index,
    output logic [batch_width(n, p)-1:0]   pe_batch,
    output logic                           leaf_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int SW = stage_width(n);
    localparam int BW = batch_width(n, p);
    localparam logic [SW-1:0] TOP_STAGE = SW'(n - 1);

    sched_state_t   state;
    logic           last_batch;
    logic [n-1:0]   next_bit;
    logic [SW-1:0]  next_stage;

    assign next_bit   = bit_index + n'(1);
    assign last_batch = (int'(pe_batch) == batches(int'(stage_index), p) - 1);
    assign leaf_valid = sched_valid && (stage_index == '0) && last_batch;

    // First stage of the next bit is its trailing-zero count (the g-function stage).
    tz_encoder #(.n(n)) u_tz (
        .value (next_bit),
        .tz    (next_stage)
    );

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sched_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_index   <= '0;
            stage_index <= TOP_STAGE;
            pe_batch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= RUN;
                        sched_valid <= 1'b1;
                        busy        <= 1'b1;
                        bit_index   <= '0;
                        stage_index <= TOP_STAGE;
                        pe_batch    <= '0;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (!last_batch) begin
                            pe_batch <= pe_batch + BW'(1);
                        end else if (stage_index != '0) begin
                            stage_index <= stage_index - SW'(1);
                            pe_batch    <= '0;
                        end else if (bit_index == {n{1'b1}}) begin
                            state       <= DONE;
                            sched_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            bit_index   <= '0;
                            stage_index <= TOP_STAGE;
                            pe_batch    <= '0;
                        end else begin
                            bit_index   <= next_bit;
                            stage_index <= next_stage;
                            pe_batch    <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_schedule_generator.sv
// Directed bench for sc_schedule_generator: three configurations against hand-built step tables.
module tb_sc_schedule_generator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // n=3, p=4
    logic       start_a, hold_a, valid_a, leaf_a, busy_a, done_a;
    logic [2:0] bit_a;
    logic [1:0] stage_a;
    logic [0:0] batch_a;
    // n=3, p=1
    logic       start_b, hold_b, valid_b, leaf_b, busy_b, done_b;
    logic [2:0] bit_b;
    logic [1:0] stage_b;
    logic [1:0] batch_b;
    // n=4, p=2
    logic       start_c, hold_c, valid_c, leaf_c, busy_c, done_c;
    logic [3:0] bit_c;
    logic [1:0] stage_c;
    logic [1:0] batch_c;

    sc_schedule_generator #(.n(3), .p(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
        .sched_valid(valid_a), .bit_index(bit_a), .stage_index(stage_a),
        .pe_batch(batch_a), .leaf_valid(leaf_a), .busy(busy_a), .done(done_a)
    );
    sc_schedule_generator #(.n(3), .p(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
        .sched_valid(valid_b), .bit_index(bit_b), .stage_index(stage_b),
        .pe_batch(batch_b), .leaf_valid(leaf_b), .busy(busy_b), .done(done_b)
    );
    sc_schedule_generator #(.n(4), .p(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .hold(hold_c),
        .sched_valid(valid_c), .bit_index(bit_c), .stage_index(stage_c),
        .pe_batch(batch_c), .leaf_valid(leaf_c), .busy(busy_c), .done(done_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int exp_bit_a[14]   = '{0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 5, 6, 6, 7};
    int exp_stage_a[14] = '{2, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0};
    int start_stage_b[8] = '{2, 0, 1, 0, 2, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects step 0 of a run to be visible on dut_a; leaves the DONE cycle visible
    // unless aborted by reset at step abort_at.
    task automatic run_a(input int hold_at, input int hold_len, input int mid_start_at,
                         input int abort_at);
        for (int k = 0; k < 14; k++) begin
            check("a_valid", 32'(valid_a), 1);
            check("a_bit", 32'(bit_a), exp_bit_a[k]);
            check("a_stage", 32'(stage_a), exp_stage_a[k]);
            check("a_leaf", 32'(leaf_a), (exp_stage_a[k] == 0) ? 1 : 0);
            check("a_busy", 32'(busy_a), 1);
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick();
                check("rst_valid", 32'(valid_a), 0);
                check("rst_bit", 32'(bit_a), 0);
                check("rst_stage", 32'(stage_a), 2);
                check("rst_busy", 32'(busy_a), 0);
                check("rst_done", 32'(done_a), 0);
                rst_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check("rst_no_done", 32'(done_a), 0);
                    check("rst_idle", 32'(valid_a), 0);
                end
                return;
            end
            if (k == hold_at) begin
                hold_a = 1'b1;
                for (int j = 0; j < hold_len; j++) begin
                    tick();
                    check("hold_valid", 32'(valid_a), 1);
                    check("hold_bit", 32'(bit_a), exp_bit_a[k]);
                    check("hold_stage", 32'(stage_a), exp_stage_a[k]);
                    check("hold_done", 32'(done_a), 0);
                end
                hold_a = 1'b0;
            end
            start_a = (k == mid_start_at);
            tick();
        end
        start_a = 1'b0;
        check("a_done", 32'(done_a), 1);
        check("a_done_busy", 32'(busy_a), 0);
        check("a_done_valid", 32'(valid_a), 0);
    endtask

    initial begin
        int steps, leaves, visits, cur_start;
        bit prev_leaf, seen_done;

        rst_n = 1'b0;
        {start_a, hold_a, start_b, hold_b, start_c, hold_c} = '0;
        tick();
        tick();
        check("rst_valid0", 32'(valid_a), 0);
        check("rst_bit0", 32'(bit_a), 0);
        check("rst_stage0", 32'(stage_a), 2);
        check("rst_batch0", 32'(batch_a), 0);
        check("rst_busy0", 32'(busy_a), 0);
        check("rst_done0", 32'(done_a), 0);
        check("rst_leaf0", 32'(leaf_a), 0);
        check("rst_stage_c", 32'(stage_c), 3);
        rst_n = 1'b1;
        tick();

        // Run 1: plain run with a stray start mid-run.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_a(-1, 0, 5, -1);
        // start and hold during DONE: done is not stretched, start is ignored.
        start_a = 1'b1;
        hold_a  = 1'b1;
        tick();
        check("done_pulse", 32'(done_a), 0);
        check("done_start_ign", 32'(valid_a), 0);
        check("idle_busy", 32'(busy_a), 0);
        hold_a = 1'b0;
        tick();
        start_a = 1'b0;
        check("restart_valid", 32'(valid_a), 1);
        check("restart_bit", 32'(bit_a), 0);
        check("restart_stage", 32'(stage_a), 2);
        // Run 2: hold for 3 cycles at bit 4 stage 1.
        run_a(8, 3, -1, -1);
        tick();
        check("idle_after_hold", 32'(done_a), 0);

        // Run 3: start under hold in IDLE, then reset at bit 5.
        start_a = 1'b1;
        hold_a  = 1'b1;
        tick();
        start_a = 1'b0;
        hold_a  = 1'b0;
        run_a(-1, 0, -1, 10);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_a(-1, 0, -1, -1);
        tick();

        // n=3, p=1: four-way and two-way batching on upper stages.
        steps  = 0;
        leaves = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int s = start_stage_b[i]; s >= 0; s--) begin
                for (int b = 0; b < (1 << s); b++) begin
                    check("b_valid", 32'(valid_b), 1);
                    check("b_bit", 32'(bit_b), i);
                    check("b_stage", 32'(stage_b), s);
                    check("b_batch", 32'(batch_b), b);
                    check("b_leaf", 32'(leaf_b), (s == 0) ? 1 : 0);
                    if (leaf_b) leaves++;
                    steps++;
                    tick();
                end
            end
        end
        check("b_steps", steps, 24);
        check("b_leaves", leaves, 8);
        check("b_done", 32'(done_b), 1);
        tick();

        // n=4, p=2: f/g consistency invariant on every valid step.
        steps     = 0;
        leaves    = 0;
        visits    = 0;
        cur_start = 0;
        prev_leaf = 1'b1;
        seen_done = 1'b0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (done_c) begin
                seen_done = 1'b1;
            end else begin
                if (valid_c) begin
                    if (prev_leaf) cur_start = int'(stage_c);
                    check("c_fg_invariant", 32'(bit_c[stage_c]),
                          (bit_c != 0 && int'(stage_c) == cur_start) ? 1 : 0);
                    if (batch_c == 0) visits++;
                    if (leaf_c) leaves++;
                    prev_leaf = leaf_c;
                    steps++;
                end
                tick();
            end
        end
        check("c_done_seen", 32'(seen_done), 1);
        check("c_steps", steps, 40);
        check("c_stage_visits", visits, 30);
        check("c_leaves", leaves, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
